// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: shared definitions for the instruction fetch stage.
//   - Default widths and reset PC for inst_fetcher.
//   - Fetch FSM state encoding (2-bit: REQ=0, WAIT=1, HOLD=2, DROP=3).
package inst_fetcher_pkg;

  localparam int unsigned  INST_W_DEF   = 32;
  localparam int unsigned  ADDR_W_DEF   = 32;
  localparam logic [31:0]  RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned  PC_STEP      = 4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // driving mem_req
    ST_WAIT = 2'd1,  // request granted, awaiting rvalid
    ST_HOLD = 2'd2,  // word buffered, downstream stalled
    ST_DROP = 2'd3   // awaiting a wrong-path response to discard
  } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_fetch_buf.sv
// fetch_buf: one-entry output buffer between the fetch FSM and IF/ID.
// Ports:
//   clk, rst          clock / async active-low reset
//   i_load            capture i_inst/i_pc and mark valid
//   i_consume         downstream took the word; clear valid
//   i_flush           redirect; clear valid (highest priority)
//   i_inst, i_pc      word and its PC to capture
//   o_valid, o_inst, o_pc  buffered word
module fetch_buf #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_consume,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;

  // A load in the same cycle as a consume replaces the departing word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch stage feeding the IF/ID register.
// Owns the PC, keeps at most one instruction-memory request outstanding,
// buffers each fetched word until decode accepts it, and discards
// wrong-path responses after a redirect.
// Ports:
//   clk, rst                 clock / async active-low reset
//   stall                    downstream will not take the word this cycle
//   redirect, redirect_pc    branch/jump taken and its target
//   mem_req, mem_addr        request to instruction memory (registered)
//   mem_gnt                  memory accepted the request
//   mem_rvalid, mem_rdata    memory response
//   inst_valid, inst_output, pc_output   buffered word to IF/ID
// Build option FETCH_PERF_EN adds perf_fetch_cnt (consumed words) and
// perf_stall_cnt (cycles with inst_valid=1 and stall=1).
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_output,
  output logic [ADDR_W-1:0] pc_output
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_req;

  logic              w_gnt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_load;
  logic              w_consume;
  logic              w_inst_valid;

  // mem_req is low in the first REQ cycle after reset, so a grant only
  // counts once the request is actually on the bus.
  assign w_gnt     = r_mem_req & mem_gnt;
  assign w_pc_inc  = r_pc + ADDR_W'(PC_STEP);
  assign w_load    = (r_state == ST_WAIT) & mem_rvalid & ~redirect;
  assign w_consume = w_inst_valid & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_REQ;
      r_pc      <= RESET_PC;
      r_mem_req <= 1'b0;
    end else if (redirect) begin
      r_pc <= redirect_pc;
      unique case (r_state)
        ST_REQ: begin
          // A grant in the redirect cycle leaves a response in flight.
          if (w_gnt) begin
            r_state   <= ST_DROP;
            r_mem_req <= 1'b0;
          end else begin
            r_state   <= ST_REQ;
            r_mem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state   <= ST_REQ;
            r_mem_req <= 1'b1;
          end else begin
            r_state   <= ST_DROP;
            r_mem_req <= 1'b0;
          end
        end
        ST_HOLD: begin
          r_state   <= ST_REQ;
          r_mem_req <= 1'b1;
        end
        ST_DROP: begin
          if (mem_rvalid) begin
            r_state   <= ST_REQ;
            r_mem_req <= 1'b1;
          end
        end
      endcase
    end else begin
      unique case (r_state)
        ST_REQ: begin
          if (w_gnt) begin
            r_state   <= ST_WAIT;
            r_mem_req <= 1'b0;
          end else begin
            r_mem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (!stall) begin
              r_pc      <= w_pc_inc;
              r_state   <= ST_REQ;
              r_mem_req <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            r_pc      <= w_pc_inc;
            r_state   <= ST_REQ;
            r_mem_req <= 1'b1;
          end
        end
        ST_DROP: begin
          if (mem_rvalid) begin
            r_state   <= ST_REQ;
            r_mem_req <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_pc;

  fetch_buf #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_flush   (redirect),
    .i_inst    (mem_rdata),
    .i_pc      (r_pc),
    .o_valid   (w_inst_valid),
    .o_inst    (inst_output),
    .o_pc      (pc_output)
  );

  assign inst_valid = w_inst_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_consume)
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_inst_valid && stall)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

  localparam int IW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          inst_valid;
  logic [IW-1:0] inst_output;
  logic [AW-1:0] pc_output;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t m_e;

  inst_fetcher #(
    .INST_W   (IW),
    .ADDR_W   (AW),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_output (inst_output),
    .pc_output   (pc_output)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every word taken downstream must be the oldest
  // word the memory was told to deliver.
  always @(negedge clk) begin
    if (rst && inst_valid && !stall) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        check("sb_pc",   64'(pc_output),   64'(m_e.pc));
        check("sb_inst", 64'(inst_output), 64'(m_e.inst));
      end
    end
  end

  // One complete fetch: optional grant delay, response one cycle after the
  // grant, optional downstream stall once the word is presented.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_wait, input int stall_cyc);
    int          guard;
    logic [31:0] nxt;
    guard = 0;
    nxt   = addr + 32'd4;
    while (mem_req !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    check("req_raised", 64'(mem_req), 64'd1);
    check("req_addr", 64'(mem_addr), 64'(addr));
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      check("req_held", 64'(mem_req), 64'd1);
      check("addr_held", 64'(mem_addr), 64'(addr));
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("req_low_after_gnt", 64'(mem_req), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    stall      = (stall_cyc > 0);
    exp_q.push_back('{pc: addr, inst: data});
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("valid_after_rvalid", 64'(inst_valid), 64'd1);
    if (stall_cyc == 0) begin
      check("next_req", 64'(mem_req), 64'd1);
      check("next_addr", 64'(mem_addr), 64'(nxt));
    end else begin
      for (int i = 0; i < stall_cyc; i++) begin
        check("hold_req_low", 64'(mem_req), 64'd0);
        check("hold_inst", 64'(inst_output), 64'(data));
        check("hold_pc", 64'(pc_output), 64'(addr));
        tick();
      end
      stall = 1'b0;
      check("hold_still_valid", 64'(inst_valid), 64'd1);
      tick();
      check("req_after_stall", 64'(mem_req), 64'd1);
      check("addr_after_stall", 64'(mem_addr), 64'(nxt));
      check("valid_drop_after_consume", 64'(inst_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_output", 64'(inst_output), 64'h0);
    check("rst_pc_output", 64'(pc_output), 64'h0);
    #20;
    rst = 1'b1;
    check("no_req_before_clock", 64'(mem_req), 64'd0);
    tick();
    check("first_req", 64'(mem_req), 64'd1);
    check("first_addr", 64'(mem_addr), 64'h0);

    // Streaming with immediate grants
    do_fetch(32'h0000_0000, 32'h1111_0001, 0, 0);
    do_fetch(32'h0000_0004, 32'h2222_0002, 0, 0);
    do_fetch(32'h0000_0008, 32'h3333_0003, 0, 0);

    // Downstream stall for 3 cycles
    do_fetch(32'h0000_000C, 32'h4444_0004, 0, 3);

    // Grant withheld 4 cycles
    do_fetch(32'h0000_0010, 32'h5555_0005, 4, 0);

    // Redirect while waiting: the late response is discarded
    check("w4_addr", 64'(mem_addr), 64'h14);
    mem_gnt = 1'b1;
    tick();
    mem_gnt     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    check("drop_req_low", 64'(mem_req), 64'd0);
    check("drop_valid_low", 64'(inst_valid), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("dropped_not_presented", 64'(inst_valid), 64'd0);
    check("redir_req", 64'(mem_req), 64'd1);
    check("redir_addr", 64'(mem_addr), 64'h100);
    do_fetch(32'h0000_0100, 32'h6666_0006, 0, 0);

    // Redirect coincident with rvalid under stall
    mem_gnt = 1'b1;
    tick();
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'hBAD0_BAD0;
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    mem_rvalid = 1'b0;
    redirect   = 1'b0;
    check("coinc_not_presented", 64'(inst_valid), 64'd0);
    check("coinc_req", 64'(mem_req), 64'd1);
    check("coinc_addr", 64'(mem_addr), 64'h200);
    stall = 1'b0;
    do_fetch(32'h0000_0200, 32'h7777_0007, 0, 0);

    // Redirect in the grant cycle
    mem_gnt     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    mem_gnt  = 1'b0;
    redirect = 1'b0;
    check("gntredir_req_low", 64'(mem_req), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_CAFE;
    tick();
    mem_rvalid = 1'b0;
    check("gntredir_not_presented", 64'(inst_valid), 64'd0);
    check("gntredir_addr", 64'(mem_addr), 64'h300);
    do_fetch(32'h0000_0300, 32'h8888_0008, 0, 0);

    // Redirect before grant to a misaligned address near the top: PC wraps
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    check("wrap_req", 64'(mem_req), 64'd1);
    check("wrap_addr", 64'(mem_addr), 64'hFFFF_FFFE);
    do_fetch(32'hFFFF_FFFE, 32'h9999_0009, 0, 0);
    do_fetch(32'h0000_0002, 32'hAAAA_000A, 0, 0);

    // Reset asserted while waiting for a response
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b0;
    #1;
    check("midrst_req", 64'(mem_req), 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'h0);
    check("midrst_valid", 64'(inst_valid), 64'd0);
    check("midrst_inst", 64'(inst_output), 64'h0);
    check("midrst_pc", 64'(pc_output), 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    #2;
    rst = 1'b1;
    check("postrst_valid", 64'(inst_valid), 64'd0);
    tick();
    check("postrst_req", 64'(mem_req), 64'd1);
    check("postrst_addr", 64'(mem_addr), 64'h0);
    do_fetch(32'h0000_0000, 32'hBBBB_000B, 0, 0);

    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_EN
    check("perf_fetch", 64'(perf_fetch_cnt), 64'd1);
    check("perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Instruction fetch stage sitting directly upstream of the IF/ID pipeline register. Owns the PC, issues one-outstanding instruction-memory requests, and holds each fetched word until the decode side accepts it. Handles redirects from branch/jump resolution, including discarding in-flight responses on the wrong path.

Parameters:
INST_W, 32, instruction width (matches `instWidth)
ADDR_W, 32, PC / memory address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall  in  1  from staller; 1 = downstream will not take the word this cycle
redirect  in  1  branch/jump taken; PC must restart at redirect_pc
redirect_pc  in  ADDR_W  target address
mem_req  out  1  request valid to instruction memory
mem_addr  out  ADDR_W  request address (PC of fetched word)
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  response data valid
mem_rdata  in  INST_W  response instruction word
inst_valid  out  1  inst_output/pc_output hold a good instruction
inst_output  out  INST_W  instruction to IF/ID
pc_output  out  ADDR_W  PC of inst_output

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=REQ, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_output=0, pc_output=0. The first request is raised on the first clock after reset release.
- States: REQ (driving mem_req), WAIT (request granted, awaiting rvalid), HOLD (word buffered, downstream stalled), DROP (awaiting a response to discard).
- REQ: mem_req=1 and mem_addr=pc, both held stable until mem_gnt. On mem_gnt, go to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata/pc into the output buffer and set inst_valid=1.
  - If stall=0 the same cycle: pc+=4 and go to REQ.
  - Else: go to HOLD.
  - Min latency from mem_gnt to inst_valid: 1 cycle after rvalid (registered output).
- HOLD: inst_valid=1, outputs stable. When stall=0: the word is consumed, inst_valid drops next cycle, pc+=4, go to REQ.
- Handshake: a word is consumed in any cycle with inst_valid=1 and stall=0; inst_valid deasserts the cycle after consumption unless a new word is captured that cycle.
- Redirect (priority over all else):
  - pc<=redirect_pc and inst_valid<=0 next cycle.
  - From REQ without gnt, or from HOLD: go to REQ.
  - From WAIT without rvalid, or from REQ with gnt the same cycle: go to DROP.
  - From WAIT with rvalid the same cycle: discard the word, go to REQ.
- DROP: mem_req=0. On mem_rvalid, discard the data and go to REQ. A further redirect in DROP only updates pc.
- pc increment wraps modulo 2^ADDR_W. Bits [1:0] of pc are passed through unchanged; misalignment is not checked.
- At most one request outstanding at any time.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds output ports perf_fetch_cnt (32) and perf_stall_cnt (32).
  - perf_fetch_cnt counts consumed words.
  - perf_stall_cnt counts cycles with inst_valid=1 and stall=1.
  - Both reset to 0 and wrap on overflow.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared include define.v: `instWidth, `addrWidth, the RESET_PC default, and the fetch state encodings (2-bit: REQ=0, WAIT=1, HOLD=2, DROP=3).
- One sub-module, fetch_buf: a one-entry output buffer holding inst/pc/valid, with load, consume and flush inputs.
- The FSM and PC logic stay in inst_fetcher.

Test Plan:
- Reset release, memory grants immediately with rvalid 1 cycle later, stall=0 → mem_addr 0x0, 0x4, 0x8…; inst_valid pulses carry the matching pc_output.
- Word arrives with stall=1 for 3 cycles → inst_output/pc_output frozen, mem_req=0 throughout; the next request is at pc+4 one cycle after stall falls.
- mem_gnt withheld 4 cycles → mem_req and mem_addr stable; exactly one request is issued.
- Redirect to 0x100 while in WAIT → the late response (e.g. 0xDEADBEEF) is dropped with inst_valid=0; the next mem_addr is 0x100.
- Redirect coincident with rvalid and stall=1 → the word is never presented; the next request is at redirect_pc.
- rst asserted mid-WAIT → outputs clear immediately; after release the fetch restarts at RESET_PC; a stale rvalid during reset is ignored.
